lsu_seq_ctrl: RTL and testbench
===============================

Name: lsu_seq_ctrl

Overview:
- Multi-cycle sequencer for the data-memory path of the single-cycle core. Replaces the fixed one-cycle load/store stall.
- Drives a synchronous-read, single-port data memory with a configurable read latency.
- Performs read-modify-write (RMW) for byte and halfword stores, and aligns and extends load data.
- Holds the PC through `o_pc_stall` until the access completes.

Parameters:
- `RD_LAT`, default 1: cycles from the `o_mem_rden` cycle's closing edge until `i_mem_rdata` is valid. Legal range 1..4.

Ports:
- `i_clk`  in  1  core clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_ld_req`  in  1  current instruction is a load (level, held while stalled).
- `i_st_req`  in  1  current instruction is a store (level, held while stalled).
- `i_addr`  in  32  effective address (ALU result).
- `i_st_data`  in  32  store source (rs2).
- `i_ld_type`  in  3  funct3 encoding: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- `i_st_type`  in  2  SB=00, SH=01, SW=10.
- `i_mem_rdata`  in  32  memory read word.
- `o_mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `o_mem_rden`  out  1  read strobe.
- `o_mem_wren`  out  1  write strobe.
- `o_mem_wdata`  out  32  merged write word.
- `o_pc_stall`  out  1  hold PC and instruction.
- `o_rd_wren`  out  1  regfile write enable for load writeback.
- `o_ld_data`  out  32  aligned and extended load result.
- `o_misalign`  out  1  misaligned-access flag.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - All outputs and latched registers are 0.
  - An in-flight write is abandoned and `o_mem_wren` drops immediately.
- States: IDLE, RD, WAIT, MERGE, WR, DONE.
- IDLE, request sampling:
  - Requests are sampled only in IDLE.
  - If both requests are high, the load wins.
- IDLE, misalignment:
  - Misaligned means halfword with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - On a misaligned request, `o_misalign=1` combinationally.
  - No stall, no memory access, no `o_rd_wren`; the FSM stays in IDLE.
- IDLE, aligned request:
  - `o_pc_stall=1` combinationally.
  - At the edge, latch addr, data and type.
  - Next state is WR for SW; otherwise RD.
- RD: `o_mem_rden=1` for exactly 1 cycle, then go to WAIT.
- WAIT:
  - Counter runs 0..RD_LAT-1.
  - At the edge ending the last WAIT cycle, capture `i_mem_rdata` into `rbuf`.
  - Next state is DONE for a load, MERGE for a store.
- MERGE (1 cycle):
  - Builds `o_mem_wdata` from `rbuf`.
  - SB replaces byte `addr[1:0]` with `st_data[7:0]`.
  - SH replaces halfword `addr[1]` with `st_data[15:0]`.
- WR (1 cycle):
  - `o_mem_wren=1`.
  - `o_mem_wdata` is the merged word (sub-word stores) or latched `st_data` (SW).
- DONE (1 cycle):
  - `o_pc_stall=0`.
  - For a load, `o_rd_wren=1` and `o_ld_data` is valid.
  - Requests are ignored; the next state is always IDLE.
- `o_pc_stall` is 1 in RD, WAIT, MERGE and WR, and in IDLE with an aligned request.
- Load extraction:
  - LB/LBU select byte `addr[1:0]`; LH/LHU select half `addr[1]`.
  - Sign-extend for LB/LH, zero-extend for LBU/LHU; LW passes through.
  - Undefined `ld_type` yields 0.
- `o_mem_addr` is driven from the latched address in every non-IDLE state and is 0 in IDLE.
- Latency, counted from the first IDLE cycle through DONE inclusive:
  - Load: RD_LAT+3 cycles.
  - SW: 3 cycles.
  - SB/SH: RD_LAT+5 cycles.
- Changes to `i_addr`/`i_st_data` after IDLE are ignored because the values are latched.
- Back-to-back memory instructions: the next request is seen in the IDLE cycle after DONE.

Decomposition:
- `lsu_pkg` holds:
  - the state enum;
  - `ld_type`/`st_type` localparams (`LB`..`LHU`, `SB`..`SW`);
  - `RD_LAT_MAX=4`.
- Sub-module `lsu_ld_align`: combinational byte/half select plus extension, taking `rbuf`, `addr[1:0]` and `ld_type`.
- The store merge stays inline.

Test Plan:
- LW at 0x100, RD_LAT=1, memory word 0xDEADBEEF → `rden` in cycle 1; DONE in cycle 3 with `o_rd_wren=1`, `o_ld_data=0xDEADBEEF`; `o_pc_stall` high in cycles 0–2.
- LB at 0x103 and LBU at 0x103 with word 0x80FF_1234 → 0xFFFFFF80 and 0x00000080; LH at 0x102 → 0xFFFF80FF.
- SB at 0x201, `st_data` 0xAA, memory 0x11223344, RD_LAT=2 → single `o_mem_wren` pulse with `wdata` 0x1122AA44 at `o_mem_addr` 0x200; total 7 cycles.
- SW at 0x204 → `wren` in cycle 1 with no `rden`; LH at 0x301 → `o_misalign` for 1 cycle, no stall, no strobes.
- Assert `i_rst_n=0` during WAIT of an SH → all outputs 0 immediately; after release, IDLE; no write was issued.
- `i_ld_req` and `i_st_req` both high → load sequence executes and `o_mem_wren` never asserts.

Source files
------------

// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared types and encodings for the load/store sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WAIT  = 3'd2,
    S_MERGE = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  localparam int RD_LAT_MAX = 4;

endpackage

`default_nettype wire

// File: rtl/lsu_ld_align.sv
// ============================================================================
// Module : lsu_ld_align
// Brief  : Selects the addressed byte/halfword of a load word and extends it.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lsu_ld_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rbuf,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_ld_type,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rbuf[7:0];
      2'd1:    w_byte = i_rbuf[15:8];
      2'd2:    w_byte = i_rbuf[23:16];
      default: w_byte = i_rbuf[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rbuf[31:16] : i_rbuf[15:0];
  end

  always_comb begin
    o_ld_data = 32'h0;
    case (i_ld_type)
      LB:      o_ld_data = {{24{w_byte[7]}}, w_byte};
      LH:      o_ld_data = {{16{w_half[15]}}, w_half};
      LW:      o_ld_data = i_rbuf;
      LBU:     o_ld_data = {24'h0, w_byte};
      LHU:     o_ld_data = {16'h0, w_half};
      default: o_ld_data = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_seq_ctrl.sv
// ============================================================================
// Module : lsu_seq_ctrl
// Brief  : Multi-cycle load/store sequencer with RMW for sub-word stores.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lsu_seq_ctrl
  import lsu_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ld_req,
  input  logic        i_st_req,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  input  logic [2:0]  i_ld_type,
  input  logic [1:0]  i_st_type,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_rden,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_wdata,
  output logic        o_pc_stall,
  output logic        o_rd_wren,
  output logic [31:0] o_ld_data,
  output logic        o_misalign
);

  localparam int             CNT_W      = $clog2(RD_LAT_MAX);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(RD_LAT - 1);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_range
    $error("lsu_seq_ctrl: RD_LAT must be within 1..RD_LAT_MAX");
  end

  lsu_state_e       r_state;
  logic [1:0]       r_off;
  logic [31:0]      r_st_data;
  logic [2:0]       r_ld_type;
  logic [1:0]       r_st_type;
  logic             r_is_load;
  logic [31:0]      r_rbuf;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [31:0]      r_mem_addr;
  logic             r_mem_rden;
  logic             r_mem_wren;
  logic [31:0]      r_wdata;
  logic             r_rd_wren;

  logic        w_idle;
  logic        w_mis_ld;
  logic        w_mis_st;
  logic        w_misalign;
  logic        w_start;
  logic        w_busy;
  logic [31:0] w_merged;
  logic [31:0] w_ld_aligned;

  // Misalignment is judged on whichever request wins arbitration (load first).
  always_comb begin
    w_idle     = (r_state == S_IDLE);
    w_mis_ld   = (((i_ld_type == LH) || (i_ld_type == LHU)) && i_addr[0]) ||
                 ((i_ld_type == LW) && (i_addr[1:0] != 2'b00));
    w_mis_st   = ((i_st_type == SH) && i_addr[0]) ||
                 ((i_st_type == SW) && (i_addr[1:0] != 2'b00));
    w_misalign = i_ld_req ? w_mis_ld : (i_st_req && w_mis_st);
    w_start    = w_idle && (i_ld_req || i_st_req) && !w_misalign;
    w_busy     = (r_state == S_RD) || (r_state == S_WAIT) ||
                 (r_state == S_MERGE) || (r_state == S_WR);
  end

  always_comb begin
    w_merged = r_rbuf;
    case (r_st_type)
      SB: begin
        case (r_off)
          2'd0:    w_merged[7:0]   = r_st_data[7:0];
          2'd1:    w_merged[15:8]  = r_st_data[7:0];
          2'd2:    w_merged[23:16] = r_st_data[7:0];
          default: w_merged[31:24] = r_st_data[7:0];
        endcase
      end
      SH: begin
        if (r_off[1]) w_merged[31:16] = r_st_data[15:0];
        else          w_merged[15:0]  = r_st_data[15:0];
      end
      default: w_merged = r_st_data;
    endcase
  end

  lsu_ld_align u_ld_align (
    .i_rbuf    (r_rbuf),
    .i_addr_lo (r_off),
    .i_ld_type (r_ld_type),
    .o_ld_data (w_ld_aligned)
  );

  // Strobes are registered alongside the transition into the state that owns them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_off      <= 2'b00;
      r_st_data  <= 32'h0;
      r_ld_type  <= 3'b000;
      r_st_type  <= 2'b00;
      r_is_load  <= 1'b0;
      r_rbuf     <= 32'h0;
      r_wait_cnt <= '0;
      r_mem_addr <= 32'h0;
      r_mem_rden <= 1'b0;
      r_mem_wren <= 1'b0;
      r_wdata    <= 32'h0;
      r_rd_wren  <= 1'b0;
    end else begin
      r_mem_rden <= 1'b0;
      r_mem_wren <= 1'b0;
      r_rd_wren  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_off      <= i_addr[1:0];
            r_st_data  <= i_st_data;
            r_ld_type  <= i_ld_type;
            r_st_type  <= i_st_type;
            r_is_load  <= i_ld_req;
            r_mem_addr <= {i_addr[31:2], 2'b00};
            if (!i_ld_req && (i_st_type == SW)) begin
              r_state    <= S_WR;
              r_mem_wren <= 1'b1;
              r_wdata    <= i_st_data;
            end else begin
              r_state    <= S_RD;
              r_mem_rden <= 1'b1;
            end
          end
        end
        S_RD: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
        end
        S_WAIT: begin
          if (r_wait_cnt == c_cnt_last) begin
            r_rbuf <= i_mem_rdata;
            if (r_is_load) begin
              r_state   <= S_DONE;
              r_rd_wren <= 1'b1;
            end else begin
              r_state <= S_MERGE;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_MERGE: begin
          r_state    <= S_WR;
          r_mem_wren <= 1'b1;
          r_wdata    <= w_merged;
        end
        S_WR: begin
          r_state <= S_DONE;
          r_wdata <= 32'h0;
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_mem_addr <= 32'h0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset gating keeps the IDLE-decoded outputs low while rst_n is held.
  assign o_misalign  = i_rst_n && w_idle && w_misalign;
  assign o_pc_stall  = i_rst_n && (w_start || w_busy);
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_rden  = r_mem_rden;
  assign o_mem_wren  = r_mem_wren;
  assign o_mem_wdata = r_wdata;
  assign o_rd_wren   = r_rd_wren;
  assign o_ld_data   = r_rd_wren ? w_ld_aligned : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_lsu_seq_ctrl.sv
// ============================================================================
// Module : tb_lsu_seq_ctrl
// Brief  : Two sequencer instances (RD_LAT=1 and 2) against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_seq_ctrl;

  typedef struct packed {
    logic [31:0] mem_addr;
    logic        rden;
    logic        wren;
    logic [31:0] wdata;
    logic        stall;
    logic        rd_wren;
    logic [31:0] ld_data;
    logic        misalign;
  } outs_t;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  lt;
    logic [1:0]  stt;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] word;
    logic [31:0] lit;
    int          cyc0;
    int          cyc1;
  } op_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ld_req [2];
  logic        st_req [2];
  logic [31:0] addr   [2];
  logic [31:0] st_data[2];
  logic [2:0]  ld_type[2];
  logic [1:0]  st_type[2];
  logic [31:0] mem_rdata[2];
  logic [31:0] mem_addr [2];
  logic        mem_rden [2];
  logic        mem_wren [2];
  logic [31:0] mem_wdata[2];
  logic        pc_stall [2];
  logic        rd_wren  [2];
  logic [31:0] ld_data  [2];
  logic        misalign [2];

  lsu_seq_ctrl #(.RD_LAT(1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ld_req(ld_req[0]), .i_st_req(st_req[0]),
    .i_addr(addr[0]), .i_st_data(st_data[0]), .i_ld_type(ld_type[0]), .i_st_type(st_type[0]),
    .i_mem_rdata(mem_rdata[0]), .o_mem_addr(mem_addr[0]), .o_mem_rden(mem_rden[0]),
    .o_mem_wren(mem_wren[0]), .o_mem_wdata(mem_wdata[0]), .o_pc_stall(pc_stall[0]),
    .o_rd_wren(rd_wren[0]), .o_ld_data(ld_data[0]), .o_misalign(misalign[0]));

  lsu_seq_ctrl #(.RD_LAT(2)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ld_req(ld_req[1]), .i_st_req(st_req[1]),
    .i_addr(addr[1]), .i_st_data(st_data[1]), .i_ld_type(ld_type[1]), .i_st_type(st_type[1]),
    .i_mem_rdata(mem_rdata[1]), .o_mem_addr(mem_addr[1]), .o_mem_rden(mem_rden[1]),
    .o_mem_wren(mem_wren[1]), .o_mem_wdata(mem_wdata[1]), .o_pc_stall(pc_stall[1]),
    .o_rd_wren(rd_wren[1]), .o_ld_data(ld_data[1]), .o_misalign(misalign[1]));

  // Memory: read data is valid only in the single cycle RD_LAT cycles after the strobe.
  logic [31:0] mem [2][256];
  int          rcnt [2];
  logic [31:0] raddr[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_rden[d]) begin
        rcnt[d]  <= d + 1;
        raddr[d] <= mem_addr[d];
      end else if (rcnt[d] > 0) begin
        rcnt[d] <= rcnt[d] - 1;
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++)
      mem_rdata[d] = (rcnt[d] == 1) ? mem[d][raddr[d][9:2]] : 32'hBAD0BAD0;
  end

  int    n_checks = 0;
  int    n_pass   = 0;
  outs_t exp_o   [2];
  logic  exp_valid[2];
  logic  chk_wd  [2];
  logic  chk_ld  [2];

  function automatic outs_t act_of(input int d);
    outs_t a;
    a.mem_addr = mem_addr[d];  a.rden    = mem_rden[d]; a.wren    = mem_wren[d];
    a.wdata    = mem_wdata[d]; a.stall   = pc_stall[d]; a.rd_wren = rd_wren[d];
    a.ld_data  = ld_data[d];   a.misalign = misalign[d];
    return a;
  endfunction

  task automatic chk32(input string nm, input int d, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s dut%0d got %h want %h", nm, d, act, want);
  endtask

  // Single compare process against the model's per-cycle expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (exp_valid[d]) begin
        outs_t a, e;
        a = act_of(d);
        e = exp_o[d];
        if (!chk_wd[d]) begin a.wdata = '0; e.wdata = '0; end
        if (!chk_ld[d]) begin a.ld_data = '0; e.ld_data = '0; end
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL cycle dut%0d t=%0t got %h want %h", d, $time, a, e);
      end
    end
  end

  function automatic logic [31:0] model_ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] t);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (t)
      3'b000:  return (b >= 32'h80)   ? b - 32'h100   : b;
      3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] a,
                                              input logic [1:0] st, input logic [31:0] sd);
    logic [31:0] m;
    if (st == 2'b00) m = 32'hFF << (8 * a);
    else             m = 32'hFFFF << (16 * a[1]);
    return (w & ~m) | ((sd << (st == 2'b00 ? 8 * a : 16 * a[1])) & m);
  endfunction

  task automatic run_op(input int d, input op_t o);
    int    lat, n, nst;
    bit    mis, sw, wr, done;
    outs_t e;
    lat = d + 1;
    nst = 0;
    mem[d][o.addr[9:2]] = o.word;
    ld_req[d] = o.ld; st_req[d] = o.st; addr[d] = o.addr;
    st_data[d] = o.sd; ld_type[d] = o.lt; st_type[d] = o.stt;
    if (o.ld) mis = (((o.lt == 3'b001) || (o.lt == 3'b101)) && o.addr[0]) ||
                    ((o.lt == 3'b010) && (o.addr[1:0] != 2'b00));
    else      mis = ((o.stt == 2'b01) && o.addr[0]) ||
                    ((o.stt == 2'b10) && (o.addr[1:0] != 2'b00));
    if (mis) begin
      e = '0;
      e.misalign = 1'b1;
      exp_o[d] = e; chk_wd[d] = 1'b1; chk_ld[d] = 1'b1; exp_valid[d] = 1'b1;
      @(posedge clk); #1;
      ld_req[d] = 1'b0; st_req[d] = 1'b0;
      return;
    end
    sw = !o.ld && (o.stt == 2'b10);
    n  = o.ld ? lat + 3 : (sw ? 3 : lat + 5);
    for (int k = 0; k < n; k++) begin
      done = (k == n - 1);
      wr   = !o.ld && (k == n - 2);
      e = '0;
      e.mem_addr = (k > 0) ? {o.addr[31:2], 2'b00} : 32'h0;
      e.stall    = !done;
      e.rden     = !sw && (k == 1);
      e.wren     = wr;
      e.wdata    = sw ? o.sd : model_merge(o.word, o.addr[1:0], o.stt, o.sd);
      e.rd_wren  = o.ld && done;
      e.ld_data  = model_ext(o.word, o.addr[1:0], o.lt);
      exp_o[d] = e; chk_wd[d] = wr; chk_ld[d] = o.ld && done; exp_valid[d] = 1'b1;
      if (k > 0) begin
        addr[d]    = $urandom;
        st_data[d] = $urandom;
      end
      @(negedge clk);
      if (pc_stall[d]) nst++;
      if (o.ld && done) chk32("lit_ld_data", d, ld_data[d], o.lit);
      if (wr)           chk32("lit_wdata", d, mem_wdata[d], o.lit);
      @(posedge clk); #1;
    end
    chk32("lit_cycles", d, 32'(nst + 1), 32'(d == 0 ? o.cyc0 : o.cyc1));
  endtask

  op_t ops[$];

  function automatic op_t mk(input logic ld, input logic st, input logic [2:0] lt, input logic [1:0] stt,
                             input logic [31:0] a, input logic [31:0] sd, input logic [31:0] w,
                             input logic [31:0] lit, input int c0, input int c1);
    op_t o;
    o.ld = ld; o.st = st; o.lt = lt; o.stt = stt; o.addr = a; o.sd = sd;
    o.word = w; o.lit = lit; o.cyc0 = c0; o.cyc1 = c1;
    return o;
  endfunction

  task automatic run_list(input int d);
    foreach (ops[i]) run_op(d, ops[i]);
    ld_req[d] = 1'b0; st_req[d] = 1'b0;
    exp_o[d] = '0; chk_wd[d] = 1'b1; chk_ld[d] = 1'b1; exp_valid[d] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    exp_valid[d] = 1'b0;
  endtask

  int wren_seen;

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ld_req[d] = 0; st_req[d] = 0; addr[d] = 0; st_data[d] = 0;
      ld_type[d] = 0; st_type[d] = 0; exp_valid[d] = 0; chk_wd[d] = 0; chk_ld[d] = 0;
      exp_o[d] = '0;
    end
    #2;
    for (int d = 0; d < 2; d++) chk32("reset_state", d, 32'(act_of(d)), 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    ops.push_back(mk(1, 0, 3'b010, 2'b00, 32'h100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 4, 5));
    ops.push_back(mk(1, 0, 3'b000, 2'b00, 32'h103, 32'h0,        32'h80FF1234, 32'hFFFFFF80, 4, 5));
    ops.push_back(mk(1, 0, 3'b100, 2'b00, 32'h103, 32'h0,        32'h80FF1234, 32'h00000080, 4, 5));
    ops.push_back(mk(1, 0, 3'b001, 2'b00, 32'h102, 32'h0,        32'h80FF1234, 32'hFFFF80FF, 4, 5));
    ops.push_back(mk(1, 0, 3'b101, 2'b00, 32'h100, 32'h0,        32'h80FF1234, 32'h00001234, 4, 5));
    ops.push_back(mk(1, 0, 3'b000, 2'b00, 32'h101, 32'h0,        32'hDEADBEEF, 32'hFFFFFFBE, 4, 5));
    ops.push_back(mk(1, 0, 3'b011, 2'b00, 32'h100, 32'h0,        32'hDEADBEEF, 32'h00000000, 4, 5));
    ops.push_back(mk(0, 1, 3'b000, 2'b00, 32'h201, 32'hFFFFFFAA, 32'h11223344, 32'h1122AA44, 6, 7));
    ops.push_back(mk(0, 1, 3'b000, 2'b01, 32'h202, 32'h5566CAFE, 32'h11223344, 32'hCAFE3344, 6, 7));
    ops.push_back(mk(0, 1, 3'b000, 2'b00, 32'h200, 32'h00000077, 32'h11223344, 32'h11223377, 6, 7));
    ops.push_back(mk(0, 1, 3'b000, 2'b00, 32'h203, 32'h00000099, 32'h11223344, 32'h99223344, 6, 7));
    ops.push_back(mk(0, 1, 3'b000, 2'b01, 32'h200, 32'h0000BEEF, 32'h11223344, 32'h1122BEEF, 6, 7));
    ops.push_back(mk(0, 1, 3'b000, 2'b10, 32'h204, 32'h12345678, 32'h0,        32'h12345678, 3, 3));
    ops.push_back(mk(1, 0, 3'b001, 2'b00, 32'h301, 32'h0,        32'h0,        32'h0,        0, 0));
    ops.push_back(mk(0, 1, 3'b000, 2'b10, 32'h306, 32'h0,        32'h0,        32'h0,        0, 0));
    ops.push_back(mk(1, 0, 3'b010, 2'b00, 32'h102, 32'h0,        32'h0,        32'h0,        0, 0));
    ops.push_back(mk(1, 1, 3'b010, 2'b10, 32'h100, 32'hCAFEF00D, 32'hDEADBEEF, 32'hDEADBEEF, 4, 5));

    fork
      run_list(0);
      run_list(1);
    join

    // Reset in the middle of an SH read-wait: outputs clear at once, no write ever issued.
    wren_seen = 0;
    for (int d = 0; d < 2; d++) begin
      mem[d][8'h80] = 32'h11223344;
      st_req[d] = 1'b1; st_type[d] = 2'b01; addr[d] = 32'h202; st_data[d] = 32'h0000ABCD;
    end
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (mem_wren[d]) wren_seen++;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk32("reset_mid_wait", d, 32'(act_of(d)), 32'h0);
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (mem_wren[d]) wren_seen++;
    end
    for (int d = 0; d < 2; d++) begin st_req[d] = 1'b0; end
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (mem_wren[d]) wren_seen++;
    end
    for (int d = 0; d < 2; d++) chk32("post_reset_idle", d, 32'(act_of(d)), 32'h0);
    chk32("reset_no_write", 0, 32'(wren_seen), 32'h0);

    @(posedge clk); #1;
    ops.delete();
    ops.push_back(mk(1, 0, 3'b010, 2'b00, 32'h100, 32'h0, 32'h0BADCAFE, 32'h0BADCAFE, 4, 5));
    fork
      run_list(0);
      run_list(1);
    join

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
